// File: rtl/ex_stage_reader.sv
// EX stage consumer of the 176-bit ID/EX bundle: operand forwarding, ALU, and
// a registered 72-bit EX/MEM bundle. Define EX_MUL_EN to add a multi-cycle
// shift-add multiplier (alu_op 4'hC) with an ex_busy stall handshake.
module ex_stage_reader #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [175:0] ID_EX,
  input  logic         ex_flush,
  input  logic         mem_fwd_we,
  input  logic [4:0]   mem_fwd_rd,
  input  logic [31:0]  mem_fwd_data,
  input  logic         wb_fwd_we,
  input  logic [4:0]   wb_fwd_rd,
  input  logic [31:0]  wb_fwd_data,
  output logic         ex_busy,
  output logic [71:0]  EX_MEM
);

  // Bundle fields
  logic            reg_con;
  logic [1:0]      mem_con;
  logic [12:0]     ex_con;
  logic [XLEN-1:0] pc, data1, data2, imm;
  logic [31:0]     instr;

  assign {reg_con, mem_con, ex_con, pc, data1, data2, imm, instr} = ID_EX;

  logic [3:0] alu_op;
  logic       b_is_imm, a_is_pc;
  logic [4:0] rs1, rs2, rd;

  assign alu_op   = ex_con[3:0];
  assign b_is_imm = ex_con[4];
  assign a_is_pc  = ex_con[5];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];

  // Reserved control bits and non-register instruction fields are not used here
  logic unused_fields;
  assign unused_fields = ^{ex_con[12:6], instr[31:25], instr[14:12], instr[6:0]};

  // Forwarding: MEM result is younger than WB, so it takes priority; x0 never forwards
  logic [XLEN-1:0] fwd_a, fwd_b;

  assign fwd_a = (mem_fwd_we && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs1) ? mem_fwd_data :
                 (wb_fwd_we  && wb_fwd_rd  != 5'd0 && wb_fwd_rd  == rs1) ? wb_fwd_data  :
                 data1;
  assign fwd_b = (mem_fwd_we && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs2) ? mem_fwd_data :
                 (wb_fwd_we  && wb_fwd_rd  != 5'd0 && wb_fwd_rd  == rs2) ? wb_fwd_data  :
                 data2;

  logic [XLEN-1:0] opnd_a, opnd_b;
  logic [4:0]      shamt;

  assign opnd_a = a_is_pc  ? pc  : fwd_a;
  assign opnd_b = b_is_imm ? imm : fwd_b;
  assign shamt  = opnd_b[4:0];

  // Single-cycle ALU; MUL (4'hC) is handled by the multiplier, never here
  logic [XLEN-1:0] alu_result;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'h0:    alu_result = opnd_a + opnd_b;
      4'h1:    alu_result = opnd_a - opnd_b;
      4'h2:    alu_result = opnd_a & opnd_b;
      4'h3:    alu_result = opnd_a | opnd_b;
      4'h4:    alu_result = opnd_a ^ opnd_b;
      4'h5:    alu_result = opnd_a << shamt;
      4'h6:    alu_result = opnd_a >> shamt;
      4'h7:    alu_result = $signed(opnd_a) >>> shamt;
      4'h8:    alu_result = ($signed(opnd_a) < $signed(opnd_b)) ? XLEN'(1) : XLEN'(0);
      4'h9:    alu_result = (opnd_a < opnd_b) ? XLEN'(1) : XLEN'(0);
      4'hA:    alu_result = opnd_b;
      4'hB:    alu_result = pc + XLEN'(4);
      default: alu_result = '0;
    endcase
  end

  logic [71:0] ex_mem_d, ex_mem_q;

`ifdef EX_MUL_EN

  localparam int unsigned CntW = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mul_a_q, mul_b_q, prod_q;
  logic [CntW-1:0] cnt_q;
  logic            hold_reg_q;
  logic [1:0]      hold_mem_q;
  logic [4:0]      hold_rd_q;
  logic            mul_start;

  assign mul_start = (state_q == StIdle) && (alu_op == 4'hC) && reg_con && !ex_flush;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Multiplier datapath: latch operands on start, one shift-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      hold_reg_q <= 1'b0;
      hold_mem_q <= 2'b00;
      hold_rd_q  <= 5'd0;
    end else if (mul_start) begin
      mul_a_q    <= opnd_a;
      mul_b_q    <= opnd_b;
      prod_q     <= '0;
      cnt_q      <= '0;
      hold_reg_q <= reg_con;
      hold_mem_q <= mem_con;
      hold_rd_q  <= rd;
    end else if (state_q == StRun) begin
      if (mul_b_q[0]) prod_q <= prod_q + mul_a_q;
      mul_a_q <= mul_a_q << 1;
      mul_b_q <= mul_b_q >> 1;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  // Next state, stall request and EX/MEM next value; flush overrides everything
  always_comb begin
    state_d  = state_q;
    ex_busy  = 1'b0;
    ex_mem_d = {reg_con, mem_con, alu_result, fwd_b, rd};
    case (state_q)
      StIdle: begin
        if (mul_start) begin
          ex_busy  = 1'b1;
          state_d  = StRun;
          ex_mem_d = '0;
        end
      end
      StRun: begin
        ex_busy  = 1'b1;
        ex_mem_d = '0;
        if (cnt_q == CntW'(MUL_CYCLES - 1)) state_d = StDone;
      end
      StDone: begin
        // ID/EX still shows the held MUL this cycle; it is ignored
        state_d  = StIdle;
        ex_mem_d = {hold_reg_q, hold_mem_q, prod_q, XLEN'(0), hold_rd_q};
      end
      default: state_d = StIdle;
    endcase
    if (ex_flush) begin
      ex_busy  = 1'b0;
      state_d  = StIdle;
      ex_mem_d = '0;
    end
  end

`else

  logic [31:0] unused_mul_cycles;
  assign unused_mul_cycles = 32'(MUL_CYCLES);

  // No multiplier: never stall; flush injects a bubble
  always_comb begin
    ex_busy  = 1'b0;
    ex_mem_d = {reg_con, mem_con, alu_result, fwd_b, rd};
    if (ex_flush) ex_mem_d = '0;
  end

`endif

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  assign EX_MEM = ex_mem_q;

endmodule

// File: tb/tb_ex_stage_reader.sv
// Self-checking bench for ex_stage_reader; MUL scenarios run when EX_MUL_EN is defined.
module tb_ex_stage_reader;

  localparam int unsigned MulCycles = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [175:0] id_ex;
  logic         ex_flush;
  logic         mem_we, wb_we;
  logic [4:0]   mem_rd, wb_rd;
  logic [31:0]  mem_data, wb_data;
  logic         ex_busy;
  logic [71:0]  ex_mem;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_stage_reader #(
    .XLEN       (32),
    .MUL_CYCLES (MulCycles)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_EX        (id_ex),
    .ex_flush     (ex_flush),
    .mem_fwd_we   (mem_we),
    .mem_fwd_rd   (mem_rd),
    .mem_fwd_data (mem_data),
    .wb_fwd_we    (wb_we),
    .wb_fwd_rd    (wb_rd),
    .wb_fwd_data  (wb_data),
    .ex_busy      (ex_busy),
    .EX_MEM       (ex_mem)
  );

  // Build a bundle; reserved Ex_Con bits and unused instruction bits are random
  function automatic logic [175:0] mk(input logic rc, input logic [1:0] mc, input logic [3:0] op,
                                      input logic bimm, input logic apc, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2,
                                      input logic [31:0] im, input logic [4:0] r1,
                                      input logic [4:0] r2, input logic [4:0] rdst);
    logic [6:0]  resv;
    logic [31:0] ins;
    resv = 7'($urandom);
    ins  = {7'($urandom), r2, r1, 3'($urandom), rdst, 7'($urandom)};
    return {rc, mc, resv, apc, bimm, op, pc, d1, d2, im, ins};
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] v);
    if (mem_we && mem_rd != 0 && mem_rd == rs) return mem_data;
    if (wb_we && wb_rd != 0 && wb_rd == rs) return wb_data;
    return v;
  endfunction

  // Reference: EX/MEM value expected after one edge for the given bundle
  function automatic logic [71:0] model(input logic [175:0] b, input logic flush);
    logic [31:0] ins, pc, va, vb, st, r;
    logic [3:0]  op;
    ins = b[31:0];
    pc  = b[159:128];
    op  = b[163:160];
    st  = pick(ins[24:20], b[95:64]);
    va  = b[165] ? pc : pick(ins[19:15], b[127:96]);
    vb  = b[164] ? b[63:32] : st;
    case (op)
      4'd0:  r = va + vb;
      4'd1:  r = va - vb;
      4'd2:  r = va & vb;
      4'd3:  r = va | vb;
      4'd4:  r = va ^ vb;
      4'd5:  r = va << vb[4:0];
      4'd6:  r = va >> vb[4:0];
      4'd7:  r = 32'($signed(va) >>> vb[4:0]);
      4'd8:  r = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      4'd9:  r = (va < vb) ? 32'd1 : 32'd0;
      4'd10: r = vb;
      4'd11: r = pc + 32'd4;
`ifdef EX_MUL_EN
      4'd12: r = va * vb;
`endif
      default: r = 32'd0;
    endcase
    if (flush) return 72'd0;
    return {b[175], b[174:173], r, st, ins[11:7]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we  = 0; wb_rd  = 0; wb_data  = 0;
  endtask

  task automatic test_reset();
    rst = 1; ex_flush = 0; clear_fwd();
    id_ex = mk(1, 2'b00, 4'd0, 0, 0, 0, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3);
    step();
    checks++;
    if (ex_mem !== 72'd0) begin failures++; $display("FAIL reset_ex_mem got=%h exp=0", ex_mem); end
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ex_busy); end
    rst = 0;
  endtask

  task automatic test_add();
    logic [71:0] exp;
    clear_fwd();
    id_ex = mk(1, 2'b00, 4'd0, 0, 0, 32'h100, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3);
    exp = model(id_ex, 0);
    step();
    checks++;
    if (ex_mem[68:37] !== 32'd12) begin
      failures++; $display("FAIL add_result got=%h exp=0000000c", ex_mem[68:37]);
    end
    checks++;
    if (ex_mem[4:0] !== 5'd3 || ex_mem[71] !== 1'b1) begin
      failures++; $display("FAIL add_rd_regcon got=%0d/%b exp=3/1", ex_mem[4:0], ex_mem[71]);
    end
    checks++;
    if (ex_mem !== exp) begin failures++; $display("FAIL add_bundle got=%h exp=%h", ex_mem, exp); end
  endtask

  task automatic test_forwarding();
    logic [31:0] expv [3];
    expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h99;
    for (int k = 0; k < 3; k++) begin
      mem_we = (k < 2); mem_rd = (k == 0) ? 5'd4 : 5'd0; mem_data = 32'h11;
      wb_we = (k < 2); wb_rd = 5'd4; wb_data = 32'h22;
      id_ex = mk(1, 2'b00, 4'd0, 1, 0, 0, 32'h99, 32'h0, 32'd0, 5'd4, 5'd9, 5'd7);
      step();
      checks++;
      if (ex_mem[68:37] !== expv[k]) begin
        failures++; $display("FAIL fwd_prio_%0d got=%h exp=%h", k, ex_mem[68:37], expv[k]);
      end
    end
    clear_fwd();
  endtask

  task automatic test_signed();
    logic [3:0]  ops  [5];
    logic [31:0] d1s  [5];
    logic        bim  [5];
    logic [31:0] expv [5];
    ops[0] = 4'd8; d1s[0] = 32'hFFFFFFFF; bim[0] = 0; expv[0] = 32'd1;
    ops[1] = 4'd9; d1s[1] = 32'hFFFFFFFF; bim[1] = 0; expv[1] = 32'd0;
    ops[2] = 4'd7; d1s[2] = 32'h80000000; bim[2] = 1; expv[2] = 32'hF8000000;
    ops[3] = 4'd6; d1s[3] = 32'h80000000; bim[3] = 1; expv[3] = 32'h08000000;
    ops[4] = 4'd11; d1s[4] = 32'h0;       bim[4] = 0; expv[4] = 32'h00000204;
    clear_fwd();
    for (int k = 0; k < 5; k++) begin
      // data2 = 1 for compares, imm = 4 for shifts, PC = 0x200
      id_ex = mk(1, 2'b00, ops[k], bim[k], 0, 32'h200, d1s[k], 32'd1, 32'd4, 5'd1, 5'd2, 5'd5);
      step();
      checks++;
      if (ex_mem[68:37] !== expv[k]) begin
        failures++; $display("FAIL signed_op%0d got=%h exp=%h", ops[k], ex_mem[68:37], expv[k]);
      end
    end
  endtask

  task automatic test_store_data();
    clear_fwd();
    wb_we = 1; wb_rd = 5'd6; wb_data = 32'hAB;
    id_ex = mk(1, 2'b01, 4'd0, 1, 0, 0, 32'h1000, 32'h55, 32'd8, 5'd5, 5'd6, 5'd10);
    step();
    checks++;
    if (ex_mem[36:5] !== 32'hAB) begin
      failures++; $display("FAIL store_data got=%h exp=000000ab", ex_mem[36:5]);
    end
    checks++;
    if (ex_mem[68:37] !== 32'h1008 || ex_mem[70:69] !== 2'b01) begin
      failures++; $display("FAIL store_alu got=%h/%b exp=00001008/01", ex_mem[68:37], ex_mem[70:69]);
    end
    clear_fwd();
  endtask

  task automatic test_flush_reset();
    id_ex = mk(1, 2'b10, 4'd0, 0, 0, 0, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3);
    ex_flush = 1;
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", ex_busy); end
    step();
    checks++;
    if (ex_mem !== 72'd0) begin failures++; $display("FAIL flush_bubble got=%h exp=0", ex_mem); end
    ex_flush = 0;
    step();
    checks++;
    if (ex_mem[68:37] !== 32'd12) begin
      failures++; $display("FAIL after_flush got=%h exp=0000000c", ex_mem[68:37]);
    end
    rst = 1;
    step();
    checks++;
    if (ex_mem !== 72'd0) begin failures++; $display("FAIL reset_mid got=%h exp=0", ex_mem); end
    rst = 0;
  endtask

  task automatic test_random();
    logic [71:0] exp;
    logic [3:0]  op;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (op == 4'hC) op = 4'h0;
`endif
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      wb_we  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_data  = $urandom;
      ex_flush = ($urandom_range(0, 9) == 0);
      id_ex = mk(1'($urandom), 2'($urandom), op, 1'($urandom), 1'($urandom), $urandom,
                 $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom));
      exp = model(id_ex, ex_flush);
      #1;
      checks++;
      if (ex_busy !== 1'b0) begin failures++; $display("FAIL rand_busy[%0d] got=%b exp=0", i, ex_busy); end
      step();
      checks++;
      if (ex_mem !== exp) begin
        failures++; $display("FAIL rand_op%0d[%0d] got=%h exp=%h", op, i, ex_mem, exp);
      end
    end
    ex_flush = 0;
    clear_fwd();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [71:0] exp;
    int          n;
    logic        leak;
    av[0] = 32'd1234;      bv[0] = 32'd5678;
    av[1] = 32'hFFFFFFFF;  bv[1] = 32'd2;
    clear_fwd();
    for (int k = 0; k < 2; k++) begin
      id_ex = mk(1, 2'b00, 4'hC, 0, 0, 0, av[k], bv[k], 0, 5'd1, 5'd2, 5'd9);
      exp = model(id_ex, 0);
      #1;
      n = 0; leak = 0;
      while (ex_busy === 1'b1 && n < 200) begin
        step();
        n++;
        if (n > 0 && ex_busy === 1'b1 && ex_mem !== 72'd0) leak = 1;
      end
      checks++;
      if (n != MulCycles + 1) begin
        failures++; $display("FAIL mul_busy_cycles[%0d] got=%0d exp=%0d", k, n, MulCycles + 1);
      end
      checks++;
      if (leak) begin failures++; $display("FAIL mul_bubble[%0d] got=nonzero exp=0", k); end
      step();
      checks++;
      if ({ex_mem[71:37], ex_mem[4:0]} !== {exp[71:37], exp[4:0]}) begin
        failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", k, ex_mem[68:37], exp[68:37]);
      end
      id_ex = 176'd0;
      #1;
      checks++;
      if (ex_busy !== 1'b0) begin failures++; $display("FAIL mul_idle[%0d] got=%b exp=0", k, ex_busy); end
    end
  endtask

  task automatic test_mul_abort();
    logic [71:0] exp;
    clear_fwd();
    // Flush during RUN cycle 10
    id_ex = mk(1, 2'b00, 4'hC, 0, 0, 0, 32'd3, 32'd4, 0, 5'd1, 5'd2, 5'd9);
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (ex_busy !== 1'b1) begin failures++; $display("FAIL abort_run_busy got=%b exp=1", ex_busy); end
    ex_flush = 1;
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", ex_busy); end
    step();
    checks++;
    if (ex_mem !== 72'd0) begin failures++; $display("FAIL abort_bubble got=%h exp=0", ex_mem); end
    ex_flush = 0;
    id_ex = mk(1, 2'b00, 4'd1, 0, 0, 0, 32'd20, 32'd6, 0, 5'd1, 5'd2, 5'd4);
    exp = model(id_ex, 0);
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", ex_busy); end
    step();
    checks++;
    if (ex_mem !== exp) begin failures++; $display("FAIL abort_next got=%h exp=%h", ex_mem, exp); end
    // Flush together with MUL issue: no start
    id_ex = mk(1, 2'b00, 4'hC, 0, 0, 0, 32'd3, 32'd4, 0, 5'd1, 5'd2, 5'd9);
    ex_flush = 1;
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", ex_busy); end
    step();
    ex_flush = 0;
    id_ex = mk(1, 2'b00, 4'd0, 0, 0, 0, 32'd8, 32'd9, 0, 5'd1, 5'd2, 5'd4);
    exp = model(id_ex, 0);
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle got=%b exp=0", ex_busy); end
    step();
    checks++;
    if (ex_mem !== exp) begin failures++; $display("FAIL flush_start_next got=%h exp=%h", ex_mem, exp); end
    // Reset mid-operation
    id_ex = mk(1, 2'b00, 4'hC, 0, 0, 0, 32'd3, 32'd4, 0, 5'd1, 5'd2, 5'd9);
    for (int c = 0; c < 5; c++) step();
    rst = 1;
    step();
    checks++;
    if (ex_mem !== 72'd0) begin failures++; $display("FAIL mul_reset got=%h exp=0", ex_mem); end
    rst = 0;
    id_ex = 176'd0;
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL mul_reset_idle got=%b exp=0", ex_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_signed();
    test_store_data();
    test_flush_reset();
    test_random();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
